// File: rtl/memory_cycle_if.sv
// Memory-stage bus bundle: M-stage inputs into memory_cycle, W-stage
// results and hazard-unit pass-throughs coming back out.
// MisalignW exists only when MEM_ALIGN_CHECK_EN is defined.
interface memory_cycle_if;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [31:0] PCPlus4M;
  logic [4:0]  RD_M;
  logic        RegWriteM;
  logic        MemWriteM;
  logic [1:0]  ResultSrcM;
  logic        StallM;

  logic [31:0] ResultW;
  logic [4:0]  RD_W;
  logic        RegWriteW;
  logic [31:0] ALUResultM_H;
  logic [4:0]  RD_M_H;
  logic        RegWriteM_H;
`ifdef MEM_ALIGN_CHECK_EN
  logic        MisalignW;
`endif

  // Upstream pipeline side: drives M-stage signals, observes W-stage results
  modport master (
    output ALUResultM, WriteDataM, PCPlus4M, RD_M, RegWriteM, MemWriteM,
           ResultSrcM, StallM,
    input  ResultW, RD_W, RegWriteW, ALUResultM_H, RD_M_H, RegWriteM_H
`ifdef MEM_ALIGN_CHECK_EN
    , input MisalignW
`endif
  );

  // memory_cycle side
  modport slave (
    input  ALUResultM, WriteDataM, PCPlus4M, RD_M, RegWriteM, MemWriteM,
           ResultSrcM, StallM,
    output ResultW, RD_W, RegWriteW, ALUResultM_H, RD_M_H, RegWriteM_H
`ifdef MEM_ALIGN_CHECK_EN
    , output MisalignW
`endif
  );
endinterface

// File: rtl/memory_cycle.sv
// Memory stage of a 5-stage RISC-V style pipeline: DEPTH x 32 data memory
// with combinational read and synchronous write, followed by the MEM/WB
// pipeline register and the write-back result mux.
// Optional feature macro: MEM_ALIGN_CHECK_EN (suppress misaligned stores
// and flag misaligned accesses on MisalignW).
module memory_cycle #(
  parameter int DEPTH = 1024
) (
  input  logic          clk,
  input  logic          rst,
  memory_cycle_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] mem_idx;
  logic [31:0]   read_data_m;
  logic          mem_we;
  logic          misalign_m;

  logic [31:0] alu_result_w_q, alu_result_w_d;
  logic [31:0] read_data_w_q,  read_data_w_d;
  logic [31:0] pc_plus4_w_q,   pc_plus4_w_d;
  logic [4:0]  rd_w_q,         rd_w_d;
  logic        reg_write_w_q,  reg_write_w_d;
  logic [1:0]  result_src_w_q, result_src_w_d;
`ifdef MEM_ALIGN_CHECK_EN
  logic        misalign_w_q,   misalign_w_d;
`endif

  // Word index (upper address bits wrap), combinational read, store enable
  always_comb begin
    mem_idx     = bus.ALUResultM[AW+1:2];
    read_data_m = mem_q[mem_idx];
    misalign_m  = (bus.ALUResultM[1:0] != 2'b00) &&
                  (bus.MemWriteM || (bus.ResultSrcM == 2'b01));
`ifdef MEM_ALIGN_CHECK_EN
    mem_we      = bus.MemWriteM && !bus.StallM && !rst &&
                  (bus.ALUResultM[1:0] == 2'b00);
`else
    mem_we      = bus.MemWriteM && !bus.StallM && !rst;
`endif
  end

  // Data memory write port; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_idx] <= bus.WriteDataM;
    end
  end

  // MEM/WB next-state: capture M-stage values unless stalled
  always_comb begin
    alu_result_w_d = alu_result_w_q;
    read_data_w_d  = read_data_w_q;
    pc_plus4_w_d   = pc_plus4_w_q;
    rd_w_d         = rd_w_q;
    reg_write_w_d  = reg_write_w_q;
    result_src_w_d = result_src_w_q;
`ifdef MEM_ALIGN_CHECK_EN
    misalign_w_d   = misalign_w_q;
`endif
    if (!bus.StallM) begin
      alu_result_w_d = bus.ALUResultM;
      read_data_w_d  = read_data_m;
      pc_plus4_w_d   = bus.PCPlus4M;
      rd_w_d         = bus.RD_M;
      reg_write_w_d  = bus.RegWriteM;
      result_src_w_d = bus.ResultSrcM;
`ifdef MEM_ALIGN_CHECK_EN
      misalign_w_d   = misalign_m;
`endif
    end
  end

  // MEM/WB register; async reset clears everything, even under stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_result_w_q <= '0;
      read_data_w_q  <= '0;
      pc_plus4_w_q   <= '0;
      rd_w_q         <= '0;
      reg_write_w_q  <= 1'b0;
      result_src_w_q <= '0;
`ifdef MEM_ALIGN_CHECK_EN
      misalign_w_q   <= 1'b0;
`endif
    end else begin
      alu_result_w_q <= alu_result_w_d;
      read_data_w_q  <= read_data_w_d;
      pc_plus4_w_q   <= pc_plus4_w_d;
      rd_w_q         <= rd_w_d;
      reg_write_w_q  <= reg_write_w_d;
      result_src_w_q <= result_src_w_d;
`ifdef MEM_ALIGN_CHECK_EN
      misalign_w_q   <= misalign_w_d;
`endif
    end
  end

  // Write-back mux and pass-throughs for the hazard unit
  always_comb begin
    case (result_src_w_q)
      2'b01:   bus.ResultW = read_data_w_q;
      2'b10:   bus.ResultW = pc_plus4_w_q;
      default: bus.ResultW = alu_result_w_q;
    endcase
    bus.RD_W         = rd_w_q;
    bus.RegWriteW    = reg_write_w_q;
    bus.ALUResultM_H = bus.ALUResultM;
    bus.RD_M_H       = bus.RD_M;
    bus.RegWriteM_H  = bus.RegWriteM;
`ifdef MEM_ALIGN_CHECK_EN
    bus.MisalignW    = misalign_w_q;
`endif
  end

`ifndef MEM_ALIGN_CHECK_EN
  // Misalignment is only reported when the check is built in
  logic unused_misalign;
  assign unused_misalign = misalign_m;
`endif

endmodule
